adder_tree_seq_ctrl: RTL
========================

// Module: adder_tree_seq_ctrl
// PURPOSE
//   Sequencer for the TLUT product reduction. It accepts one DIM_A-wide product row per
//   handshake and accumulates DIM_C rows column-wise into DIM_A accumulators. It then
//   presents the DIM_A results through a valid/ready output handshake.
//   It sits between the TLUT product generator and the matrix-multiply result consumer.
//   It replaces the one-shot full-matrix reduction with a time-multiplexed one.
// PARAMETERS
//   DIM_C      4   rows (product terms) summed per result batch; must be >= 1
//   DIM_A      4   output lanes (columns) per row
//   ACC_WIDTH  16  width of each product lane and accumulator, in bits
// PORTS
//   clk        in   1                  clock; all state updates on the rising edge
//   rst        in   1                  asynchronous, active-high reset
//   flush      in   1                  synchronous abort; discards any partial batch
//   in_valid   in   1                  in_row holds a valid product row
//   in_ready   out  1                  block accepts a row this cycle
//   in_row     in   DIM_A*ACC_WIDTH    product row; lane a = [a*ACC_WIDTH +: ACC_WIDTH]
//   out_valid  out  1                  out_mult holds a completed batch
//   out_ready  in   1                  consumer takes out_mult this cycle
//   out_mult   out  DIM_A*ACC_WIDTH    column sums; lane packing same as in_row
//   busy       out  1                  a batch is in progress or awaiting output
//   row_cnt    out  $clog2(DIM_C+1)    rows accepted in the current batch
// BEHAVIOUR
//   - Reset (rst=1, async): state=IDLE, all accumulators=0, row_cnt=0, out_valid=0,
//     in_ready=0 while rst is high, busy=0, out_mult=0.
//   - Accept: a row is accepted on a rising edge where in_valid && in_ready.
//   - States and in_ready:
//       IDLE  in_ready=1
//       ACCUM in_ready=1
//       DONE  in_ready=0
//   - IDLE, row accepted:
//       acc[a] <= lane a (load, not add); row_cnt <= 1.
//       Next state: DONE if DIM_C==1, otherwise ACCUM.
//   - ACCUM, row accepted:
//       acc[a] <= acc[a] + lane a; row_cnt++.
//       On the row that makes row_cnt==DIM_C, go to DONE.
//   - ACCUM, no row accepted: hold. Bubbles on in_valid are allowed and have no effect.
//   - DONE:
//       out_valid=1; out_mult=acc, stable while out_valid && !out_ready.
//       On out_valid && out_ready: IDLE, row_cnt <= 0, accumulators retain their value.
//       The next batch overwrites them by load.
//   - Latency: out_valid rises on the cycle after the edge that accepted the DIM_C-th row.
//     Minimum batch period is DIM_C+1 cycles.
//   - Arithmetic: unsigned modulo 2^ACC_WIDTH. Wrap-around, no saturation, no overflow flag.
//   - out_mult drives acc in every state. Consumers sample it only when out_valid=1.
//   - busy = (state != IDLE).
//   - flush: highest priority after rst.
//       Next state IDLE, accumulators=0, row_cnt=0, out_valid=0.
//       Any row offered in the flush cycle is discarded.
//       A flush in DONE drops the pending result even if out_ready=1.
//   - An output handshake and a new in_valid in the same cycle: the row is not accepted,
//     because in_ready=0 in DONE. It is accepted at the earliest on the following cycle,
//     in IDLE.
//   - rst asserted mid-batch: immediate return to reset values; partial sums are lost.
//   - All outputs are registered or decoded from state only. There is no combinational
//     path from in_* to out_*.
// TESTING   (DIM_C=4, DIM_A=4, ACC_WIDTH=16)
//   1. Four back-to-back rows of [1,2,3,4]:
//      -> out_valid on the 5th edge after the first accept; out_mult=[4,8,12,16].
//   2. Lane0 rows 0xFFFF,0x0001,0x0000,0x0002, other lanes 0:
//      -> out_mult lane0=0x0002 (wrap); other lanes 0.
//   3. Batch complete with out_ready held low for 3 cycles:
//      -> out_valid=1, out_mult stable, in_ready=0 throughout.
//      -> out_ready=1 gives a handshake; out_valid=0 and busy=0 on the next cycle.
//   4. Rows [1,1,1,1]x4 with 2 idle cycles between each:
//      -> out_mult=[4,4,4,4]; row_cnt steps 1,2,3,4.
//   5. Accept 2 rows of [9,9,9,9], then flush=1, then 4 rows of [5,6,7,8]:
//      -> out_mult=[20,24,28,32], with no residue from the flushed rows.
//   6. rst pulsed asynchronously mid-clock after 3 rows:
//      -> outputs go to reset values immediately.
//      -> A fresh 4-row batch of [2,2,2,2] gives [8,8,8,8].

Source files
------------

// File: rtl/adder_tree_seq_ctrl.sv
// Time-multiplexed column reduction: sums DIM_C product rows lane-wise into DIM_A accumulators.
// Latency: out_valid rises the cycle after the DIM_C-th row is accepted; min batch period DIM_C+1.
// Backpressure: in_ready drops while a result is held; the result stays stable until out_ready.
module adder_tree_seq_ctrl #(
  parameter int DIM_C     = 4,
  parameter int DIM_A     = 4,
  parameter int ACC_WIDTH = 16,
  localparam int CNT_W    = $clog2(DIM_C + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIM_A*ACC_WIDTH-1:0] in_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM_A*ACC_WIDTH-1:0] out_mult,
  output logic                       busy,
  output logic [CNT_W-1:0]           row_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc [DIM_A];
  logic                 accept;
  logic                 last_row;

  // Outputs are decoded from state only; rst gates in_ready so nothing is taken during reset.
  assign in_ready  = !rst && (state != DONE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_row  = (row_cnt == CNT_W'(DIM_C - 1));

  // Pack accumulators onto the result bus using the same lane layout as in_row.
  always_comb begin
    out_mult = '0;
    for (int a = 0; a < DIM_A; a++) begin
      out_mult[a*ACC_WIDTH +: ACC_WIDTH] = acc[a];
    end
  end

  // Next-state decode; flush overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (DIM_C == 1) ? DONE : ACCUM;
      ACCUM:   if (accept && last_row) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accumulators and row counter: first row of a batch loads, later rows add (mod 2^ACC_WIDTH).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DIM_A; a++) acc[a] <= '0;
      row_cnt <= '0;
    end else if (flush) begin
      for (int a = 0; a < DIM_A; a++) acc[a] <= '0;
      row_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int a = 0; a < DIM_A; a++) acc[a] <= in_row[a*ACC_WIDTH +: ACC_WIDTH];
            row_cnt <= CNT_W'(1);
          end
        end
        ACCUM: begin
          if (accept) begin
            for (int a = 0; a < DIM_A; a++) acc[a] <= acc[a] + in_row[a*ACC_WIDTH +: ACC_WIDTH];
            row_cnt <= row_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Accumulators keep the result; the next batch overwrites them by load.
          if (out_ready) row_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
